// File: rtl/ppu_lcd_timing.sv
// LCD timing generator for the PPU: dot/line counters, mode decode, LYC compare
// and one-cycle STAT / VBLANK interrupt pulses for the interrupt controller.
`timescale 1ns/1ps
module ppu_lcd_timing #(
  parameter int unsigned DOTS_PER_LINE = 456,
  parameter int unsigned VISIBLE_LINES = 144,
  parameter int unsigned TOTAL_LINES   = 154,
  parameter int unsigned OAM_DOTS      = 80,
  parameter int unsigned DRAW_DOTS     = 172
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_enable,
  input  logic [3:0] stat_ie,
  input  logic [7:0] lyc,
  output logic [7:0] ly,
  output logic [8:0] dot,
  output logic [1:0] mode,
  output logic       lyc_match,
  output logic       pixel_active,
  output logic [7:0] pixel_x,
  output logic       line_start,
  output logic       frame_start,
  output logic       stat_irq,
  output logic       vblank_irq
);

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_DRAW   = 2'd3
  } mode_e;

  localparam logic [8:0] DOT_LAST     = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] DRAW_FIRST   = 9'(OAM_DOTS);
  localparam logic [8:0] HBLANK_FIRST = 9'(OAM_DOTS + DRAW_DOTS);
  localparam logic [7:0] LY_LAST      = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] VBLANK_FIRST = 8'(VISIBLE_LINES);
  localparam logic [7:0] PIXEL_BASE   = 8'(OAM_DOTS);

  mode_e mode_d;
  logic  active;
  logic  stat_line;
  logic  stat_line_q;

  // The counters sit at 0/0 both while disabled and while reset is held, which
  // would otherwise decode as mode 2 / line start; every decode is gated here.
  assign active = lcd_enable & ~reset;

  // NOTE: combinational blocks assign every output a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mode_d = MODE_HBLANK;
    if (active) begin
      if (ly >= VBLANK_FIRST)      mode_d = MODE_VBLANK;
      else if (dot < DRAW_FIRST)   mode_d = MODE_OAM;
      else if (dot < HBLANK_FIRST) mode_d = MODE_DRAW;
    end
  end

  assign mode         = mode_d;
  assign lyc_match    = active & (ly == lyc);
  assign pixel_active = (mode_d == MODE_DRAW);
  assign pixel_x      = pixel_active ? (dot[7:0] - PIXEL_BASE) : '0;
  assign line_start   = active & (dot == '0);
  assign frame_start  = line_start & (ly == '0);

  assign stat_line = active & ((stat_ie[0] & (mode_d == MODE_HBLANK)) |
                               (stat_ie[1] & (mode_d == MODE_VBLANK)) |
                               (stat_ie[2] & (mode_d == MODE_OAM))    |
                               (stat_ie[3] & lyc_match));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ly          <= '0;
      dot         <= '0;
      stat_line_q <= 1'b0;
      stat_irq    <= 1'b0;
      vblank_irq  <= 1'b0;
    end else if (!lcd_enable) begin
      ly          <= '0;
      dot         <= '0;
      stat_line_q <= 1'b0;
      stat_irq    <= 1'b0;
      vblank_irq  <= 1'b0;
    end else begin
      if (dot == DOT_LAST) begin
        dot <= '0;
        ly  <= (ly == LY_LAST) ? 8'd0 : ly + 8'd1;
      end else begin
        dot <= dot + 9'd1;
      end
      // A rise while another source already holds the line high is swallowed.
      stat_line_q <= stat_line;
      stat_irq    <= stat_line & ~stat_line_q;
      vblank_irq  <= (ly == VBLANK_FIRST) && (dot == '0);
    end
  end

endmodule
